// File: rtl/inertial_pkg.sv
// Shared types and constants for the inertial sensor SPI front end.
package inertial_pkg;

  // Top-level sequencing states
  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_CFG1,
    ST_CFG2,
    ST_CFG3,
    ST_CFG4,
    ST_WAIT_INT,
    ST_RD_PL,
    ST_RD_PH,
    ST_RD_AL,
    ST_RD_AH
  } inert_state_t;

  // SPI shifter states
  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_XFER,
    SPI_FIN
  } spi_state_t;

  // Sensor configuration writes, issued once after power-up
  localparam logic [15:0] CFG_INT_EN = 16'h0D02;  // INT on data ready
  localparam logic [15:0] CFG_ACCEL  = 16'h1053;  // accel 208Hz +/-2g
  localparam logic [15:0] CFG_GYRO   = 16'h1150;  // gyro 208Hz 250dps
  localparam logic [15:0] CFG_ROUND  = 16'h1460;  // rounding

  // Output data register addresses
  localparam logic [6:0] ADDR_PTCH_L = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H = 7'h23;
  localparam logic [6:0] ADDR_AZ_L   = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H   = 7'h2D;

  // Read command: R/W bit set, address, don't-care payload sent as zero
  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/inertial_if.sv
// Sensor pins plus the sample stream to the pitch integrator.
interface inertial_if;
  logic        INT;
  logic        MISO;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;

  modport master (
    input  INT, MISO,
    output SS_n, SCLK, MOSI, vld, ptch_rt, AZ
  );

  modport slave (
    output INT, MISO,
    input  SS_n, SCLK, MOSI, vld, ptch_rt, AZ
  );
endinterface

// File: rtl/spi_mnrch.sv
// 16-bit SPI initiator, mode 3 (SCLK idles high), MSB first.
//
//  state    | meaning
//  SPI_IDLE | SS_n high, waiting for wrt
//  SPI_XFER | shifting; SCLK falls at div==0, rises at div==half
//  SPI_FIN  | SS_n just released; done fires on the next edge
module spi_mnrch #(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);
  import inertial_pkg::*;

  localparam logic [SCLK_DIV_W-1:0] DIV_HALF = {1'b1, {(SCLK_DIV_W-1){1'b0}}};

  spi_state_t            state_q, state_d;
  logic [SCLK_DIV_W-1:0] div_q;
  logic [4:0]            bit_cnt_q;
  logic [15:0]           tx_q;
  logic [15:0]           rx_q;
  logic                  fall, rise, finish;

  assign rd_data = rx_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SPI_IDLE;
    else     state_q <= state_d;
  end

  // Next state and SCLK edge decisions
  always_comb begin
    state_d = state_q;
    fall    = 1'b0;
    rise    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      SPI_IDLE: if (wrt) state_d = SPI_XFER;
      SPI_XFER: begin
        if (div_q == '0) begin
          // After the 16th rise, the next would-be fall releases SS_n instead
          if (bit_cnt_q == 5'd16) begin
            finish  = 1'b1;
            state_d = SPI_FIN;
          end else begin
            fall = 1'b1;
          end
        end else if (div_q == DIV_HALF) begin
          rise = 1'b1;
        end
      end
      SPI_FIN:  state_d = SPI_IDLE;
      default:  state_d = SPI_IDLE;
    endcase
  end

  // Pins, divider and shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      MOSI      <= 1'b0;
      done      <= 1'b0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
    end else begin
      done <= (state_q == SPI_FIN);
      if (state_q == SPI_IDLE && wrt) begin
        SS_n      <= 1'b0;
        div_q     <= '0;
        bit_cnt_q <= '0;
        tx_q      <= cmd;
      end
      if (state_q == SPI_XFER) div_q <= div_q + SCLK_DIV_W'(1);
      if (fall) begin
        SCLK <= 1'b0;
        MOSI <= tx_q[15];
        tx_q <= {tx_q[14:0], 1'b0};
      end
      if (rise) begin
        SCLK      <= 1'b1;
        rx_q      <= {rx_q[14:0], MISO};
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (finish) SS_n <= 1'b1;
    end
  end

endmodule

// File: rtl/inertial_intf.sv
// Inertial sensor front end: power-up wait, configuration, sample reads.
//
//  state        | meaning
//  ST_INIT_WAIT | waiting out sensor power-up
//  ST_CFG1..4   | one configuration write each
//  ST_WAIT_INT  | idle until synchronised INT is high
//  ST_RD_PL/PH  | reading pitch rate low/high byte
//  ST_RD_AL/AH  | reading Z accel low/high byte; AH done publishes the sample
module inertial_intf #(
  parameter int INIT_WAIT_W = 16,
  parameter int SCLK_DIV_W  = 5
) (
  input  logic        clk,
  input  logic        rst,
  inertial_if.master  bus
);
  import inertial_pkg::*;

  inert_state_t           state_q, state_d;
  logic [INIT_WAIT_W-1:0] pwr_cnt_q;
  logic                   pwr_sat;
  logic                   int_meta_q, int_sync_q;
  logic                   wrt;
  logic [15:0]            cmd;
  logic                   done;
  logic [15:0]            rd_data;
  logic [7:0]             pl_q, ph_q, al_q;
  logic [15:0]            ptch_q, az_q;
  logic                   vld_q;
  logic                   unused_rd_hi;

  assign pwr_sat      = &pwr_cnt_q;
  assign unused_rd_hi = ^rd_data[15:8];
  assign bus.vld      = vld_q;
  assign bus.ptch_rt  = ptch_q;
  assign bus.AZ       = az_q;

  spi_mnrch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (bus.MISO),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (bus.SS_n),
    .SCLK    (bus.SCLK),
    .MOSI    (bus.MOSI)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT_WAIT;
    else     state_q <= state_d;
  end

  // Next state; each transaction is launched on the edge that enters its state
  always_comb begin
    state_d = state_q;
    wrt     = 1'b0;
    cmd     = '0;
    case (state_q)
      ST_INIT_WAIT: if (pwr_sat) begin state_d = ST_CFG1; wrt = 1'b1; cmd = CFG_INT_EN; end
      ST_CFG1:      if (done) begin state_d = ST_CFG2; wrt = 1'b1; cmd = CFG_ACCEL; end
      ST_CFG2:      if (done) begin state_d = ST_CFG3; wrt = 1'b1; cmd = CFG_GYRO; end
      ST_CFG3:      if (done) begin state_d = ST_CFG4; wrt = 1'b1; cmd = CFG_ROUND; end
      ST_CFG4:      if (done) state_d = ST_WAIT_INT;
      ST_WAIT_INT:  if (int_sync_q) begin state_d = ST_RD_PL; wrt = 1'b1; cmd = rd_cmd(ADDR_PTCH_L); end
      ST_RD_PL:     if (done) begin state_d = ST_RD_PH; wrt = 1'b1; cmd = rd_cmd(ADDR_PTCH_H); end
      ST_RD_PH:     if (done) begin state_d = ST_RD_AL; wrt = 1'b1; cmd = rd_cmd(ADDR_AZ_L); end
      ST_RD_AL:     if (done) begin state_d = ST_RD_AH; wrt = 1'b1; cmd = rd_cmd(ADDR_AZ_H); end
      ST_RD_AH:     if (done) state_d = ST_WAIT_INT;
      default:      state_d = ST_INIT_WAIT;
    endcase
  end

  // Power-up counter, saturates and then stays put until the next reset
  always_ff @(posedge clk) begin
    if (rst)                                     pwr_cnt_q <= '0;
    else if (state_q == ST_INIT_WAIT && !pwr_sat) pwr_cnt_q <= pwr_cnt_q + INIT_WAIT_W'(1);
  end

  // Two-flop synchroniser for the asynchronous INT pin
  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta_q <= 1'b0;
      int_sync_q <= 1'b0;
    end else begin
      int_meta_q <= bus.INT;
      int_sync_q <= int_meta_q;
    end
  end

  // Byte capture; both words publish together with the vld strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      pl_q   <= '0;
      ph_q   <= '0;
      al_q   <= '0;
      ptch_q <= '0;
      az_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (done) begin
        case (state_q)
          ST_RD_PL: pl_q <= rd_data[7:0];
          ST_RD_PH: ph_q <= rd_data[7:0];
          ST_RD_AL: al_q <= rd_data[7:0];
          ST_RD_AH: begin
            ptch_q <= {ph_q, pl_q};
            az_q   <= {rd_data[7:0], al_q};
            vld_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inertial_intf.sv
// Directed bench for inertial_intf with a register-file sensor model.
module tb_inertial_intf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inertial_if bus();

  inertial_intf #(.INIT_WAIT_W(4), .SCLK_DIV_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sensor model state
  logic [7:0]  sregs [0:127];
  logic [15:0] wr_log [$];
  logic [6:0]  rd_log [$];
  int          ah_cnt = 0;
  int          ph9_cnt = 0;
  int          int_target = 0;
  logic        int_en = 1'b0;
  assign bus.INT = int_en && (ah_cnt < int_target);

  // Stream monitor state
  int          vld_cnt = 0;
  logic [15:0] snap_pr, snap_az;

  int          cyc = 0, live_cyc = 0;
  int          ss_fall_cyc = 0, ss_rise_cyc = 0, rise_cyc = 0;
  int          nbits = 0, nfalls = 0;
  logic [15:0] sh;
  logic        is_rd = 1'b0;
  logic [6:0]  addr = '0;
  logic        first_ss = 1'b1;
  logic        ss_p = 1'b1, sclk_p = 1'b1, mosi_p = 1'b0, vld_p = 1'b0;

  // Sensor model and pin/timing monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      live_cyc = 0;
      first_ss = 1'b1;
      bus.MISO = 1'b0;
    end else begin
      live_cyc++;
    end
    if (ss_p && bus.SS_n === 1'b0) begin
      chk("ss_gap", 32'((cyc - ss_rise_cyc) >= 2), 1);
      if (first_ss) begin
        chk("pwr_wait", live_cyc, 17);
        first_ss = 1'b0;
      end
      nbits = 0; nfalls = 0; sh = '0; is_rd = 1'b0; addr = '0;
      ss_fall_cyc = cyc;
    end
    if (!ss_p && bus.SS_n === 1'b0) begin
      if (sclk_p && !bus.SCLK) begin
        if (nfalls == 0) chk("ss_to_sclk", cyc - ss_fall_cyc, 1);
        bus.MISO = (nbits >= 8 && is_rd) ? sregs[addr][15-nbits] : 1'b0;
        nfalls++;
        if (nfalls == 9 && is_rd && addr == 7'h23) ph9_cnt++;
      end
      if (!sclk_p && bus.SCLK) begin
        chk("mosi_stable", bus.MOSI, mosi_p);
        if (nbits > 0) chk("sclk_period", cyc - rise_cyc, 32);
        rise_cyc = cyc;
        sh = {sh[14:0], bus.MOSI};
        nbits++;
        if (nbits == 8) begin
          is_rd = sh[7];
          addr  = sh[6:0];
          if (is_rd) begin
            rd_log.push_back(addr);
            if (addr == 7'h2D) ah_cnt++;
          end
        end
      end
    end
    if (!ss_p && bus.SS_n === 1'b1) begin
      if (nbits == 16) begin
        chk("ss_after_rise", cyc - rise_cyc, 16);
        if (!sh[15]) wr_log.push_back(sh);
      end
      ss_rise_cyc = cyc;
    end
    if (bus.SS_n === 1'b1) chk("sclk_idle", bus.SCLK, 1);
    if (bus.vld === 1'b1) begin
      chk("vld_pulse", vld_p, 0);
      vld_cnt++;
      snap_pr = bus.ptch_rt;
      snap_az = bus.AZ;
    end
    ss_p = bus.SS_n; sclk_p = bus.SCLK; mosi_p = bus.MOSI; vld_p = bus.vld;
  end

  task automatic wait_vld(input int n, input string tag);
    int t = 0;
    while (vld_cnt < n && t < 5000) begin @(negedge clk); t++; end
    chk(tag, 32'(vld_cnt >= n), 1);
  endtask

  task automatic wait_wr(input int n, input string tag);
    int t = 0;
    while (wr_log.size() < n && t < 5000) begin @(negedge clk); t++; end
    chk(tag, 32'(wr_log.size() >= n), 1);
  endtask

  task automatic set_regs(input logic [7:0] pl, ph, al, ah);
    sregs[7'h22] = pl; sregs[7'h23] = ph; sregs[7'h2C] = al; sregs[7'h2D] = ah;
  endtask

  task automatic check_cfg(input int base, input string tag);
    logic [15:0] exp_cfg [4];
    exp_cfg = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    for (int i = 0; i < 4; i++)
      if (base + i < wr_log.size()) chk(tag, wr_log[base+i], exp_cfg[i]);
  endtask

  logic [7:0] t4_data [3][4];
  logic [6:0] exp_rd  [4];
  int vbase, rbase, wbase, pbase, t;

  initial begin
    t4_data = '{'{8'h11, 8'h22, 8'h33, 8'h44},
                '{8'hF0, 8'h7F, 8'h01, 8'h80},
                '{8'h5A, 8'hA5, 8'hC3, 8'h3C}};
    exp_rd  = '{7'h22, 7'h23, 7'h2C, 7'h2D};
    for (int i = 0; i < 128; i++) sregs[i] = 8'h00;

    // T1: reset values, then power-up wait and the four config writes
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss_n", bus.SS_n, 1);
    chk("rst_sclk", bus.SCLK, 1);
    chk("rst_mosi", bus.MOSI, 0);
    chk("rst_vld", bus.vld, 0);
    chk("rst_ptch", bus.ptch_rt, 16'h0000);
    chk("rst_az", bus.AZ, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    wait_wr(4, "t1_wr_timeout");
    repeat (20) @(negedge clk);
    chk("t1_wr_count", wr_log.size(), 4);
    check_cfg(0, "t1_cfg");
    chk("t1_no_vld", vld_cnt, 0);

    // T2: one sample, then outputs hold
    set_regs(8'h34, 8'h12, 8'hCD, 8'hAB);
    int_target = ah_cnt + 1;
    int_en = 1'b1;
    wait_vld(1, "t2_vld_timeout");
    chk("t2_ptch", snap_pr, 16'h1234);
    chk("t2_az", snap_az, 16'hABCD);
    repeat (100) @(negedge clk);
    chk("t2_one_vld", vld_cnt, 1);
    chk("t2_ptch_hold", bus.ptch_rt, 16'h1234);
    chk("t2_az_hold", bus.AZ, 16'hABCD);

    // T3: negative extremes keep their sign
    set_regs(8'h00, 8'h80, 8'hFF, 8'hFF);
    int_target = ah_cnt + 1;
    wait_vld(2, "t3_vld_timeout");
    chk("t3_ptch", 32'($signed(snap_pr)), 32'(-32768));
    chk("t3_az", 32'($signed(snap_az)), 32'(-1));

    // T4: INT held for three samples, fresh data each time
    vbase = vld_cnt;
    rbase = rd_log.size();
    set_regs(t4_data[0][0], t4_data[0][1], t4_data[0][2], t4_data[0][3]);
    int_target = ah_cnt + 3;
    for (int s = 0; s < 3; s++) begin
      wait_vld(vbase + s + 1, "t4_vld_timeout");
      chk("t4_ptch", snap_pr, {t4_data[s][1], t4_data[s][0]});
      chk("t4_az", snap_az, {t4_data[s][3], t4_data[s][2]});
      if (s < 2) set_regs(t4_data[s+1][0], t4_data[s+1][1], t4_data[s+1][2], t4_data[s+1][3]);
    end
    repeat (600) @(negedge clk);
    chk("t4_vld_count", vld_cnt - vbase, 3);
    chk("t4_rd_count", rd_log.size() - rbase, 12);
    for (int i = 0; i < 12; i++)
      if (rbase + i < rd_log.size()) chk("t4_rd_order", rd_log[rbase+i], exp_rd[i%4]);

    // T5: reset in the 9th SCLK of RD_PH aborts and restarts init
    vbase = vld_cnt;
    pbase = ph9_cnt;
    set_regs(8'h01, 8'h02, 8'h03, 8'h04);
    int_target = ah_cnt + 5;
    t = 0;
    while (ph9_cnt == pbase && t < 5000) begin @(negedge clk); t++; end
    chk("t5_ph9_timeout", 32'(ph9_cnt > pbase), 1);
    wbase = wr_log.size();
    @(posedge clk); #1 rst = 1'b1; int_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_ss_n", bus.SS_n, 1);
    chk("t5_sclk", bus.SCLK, 1);
    chk("t5_vld", bus.vld, 0);
    chk("t5_ptch", bus.ptch_rt, 16'h0000);
    chk("t5_az", bus.AZ, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    wait_wr(wbase + 4, "t5_wr_timeout");
    repeat (20) @(negedge clk);
    chk("t5_wr_count", wr_log.size() - wbase, 4);
    check_cfg(wbase, "t5_cfg");
    chk("t5_no_vld", vld_cnt, vbase);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
